// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 UART receiver with 16x oversampling.
//
// The asynchronous serial input is synchronised through two flops. A tick
// generator divides i_clk down to 16 ticks per bit and is re-phased on every
// start edge. The FSM confirms the start bit at mid-bit, then samples the
// eight data bits (LSB first) and the stop bit at bit centres.
//
// Optional build macro: UART_RX_PARITY_EN
//   When defined, a PARITY state follows DATA and the frame becomes 8-E-1.
//   When undefined, o_parity_err is constantly 0.
//
// Parameters:
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        line bit rate in bit/s
//   OVERSAMPLE  ticks per bit (only 16 is supported)
//
// Ports:
//   i_clk         system clock
//   i_reset       synchronous active-high reset
//   i_rxd         asynchronous serial input, idle high
//   o_data        last good received byte
//   o_valid       one-cycle pulse: o_data holds a new good byte
//   o_frame_err   one-cycle pulse: stop bit sampled low
//   o_parity_err  one-cycle pulse: even-parity mismatch (0 without the option)
//   o_busy        high whenever the receiver is not idle
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned SAMPLE_W = 4;
  localparam int unsigned DIV_RAW  = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned TICK_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(DIV - 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_MID  = SAMPLE_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  state_t state, state_next;

  logic              rx_meta;
  logic              rxs;
  logic              rxs_prev;
  logic              fall;
  logic              tick;
  logic [TICK_W-1:0] tick_cnt;

  logic [SAMPLE_W-1:0] sample_cnt, sample_next;
  logic [IDX_W-1:0]    bit_idx, bit_next;
  logic [DATA_W-1:0]   shift, shift_next;
  logic [DATA_W-1:0]   data_next;
  logic                valid_next;
  logic                ferr_next;

`ifdef UART_RX_PARITY_EN
  logic parity_bit, parity_next;
  logic perr_next;
`endif

  // Two-flop synchroniser plus previous-sample register for edge detection
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= i_rxd;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  assign fall = rxs_prev & ~rxs;
  assign tick = (tick_cnt == TICK_LAST);

  // Tick divider; re-phased on the start edge so samples land at bit centres
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tick_cnt <= '0;
    end else if ((state == IDLE) && fall) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sample_cnt  <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit   <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      sample_cnt  <= sample_next;
      bit_idx     <= bit_next;
      shift       <= shift_next;
      o_data      <= data_next;
      o_valid     <= valid_next;
      o_frame_err <= ferr_next;
      // Registered from next state so it tracks the state register exactly
      o_busy      <= (state_next != IDLE);
`ifdef UART_RX_PARITY_EN
      parity_bit   <= parity_next;
      o_parity_err <= perr_next;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign o_parity_err = 1'b0;
`endif

  // Next-state, datapath and strobe decode
  always_comb begin
    state_next  = state;
    sample_next = sample_cnt;
    bit_next    = bit_idx;
    shift_next  = shift;
    data_next   = o_data;
    valid_next  = 1'b0;
    ferr_next   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_next = parity_bit;
    perr_next   = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        if (fall) begin
          sample_next = '0;
          state_next  = START;
        end
      end

      START: begin
        if (tick) begin
          if (sample_cnt == SAMPLE_MID) begin
            // Mid start bit: a high line here means the edge was a glitch
            if (!rxs) begin
              sample_next = '0;
              bit_next    = '0;
              state_next  = DATA;
            end else begin
              state_next = IDLE;
            end
          end else begin
            sample_next = sample_cnt + SAMPLE_W'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (sample_cnt == SAMPLE_LAST) begin
            sample_next = '0;
            shift_next  = {rxs, shift[DATA_W-1:1]};
            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              bit_next = bit_idx + IDX_W'(1);
            end
          end else begin
            sample_next = sample_cnt + SAMPLE_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (sample_cnt == SAMPLE_LAST) begin
            sample_next = '0;
            parity_next = rxs;
            state_next  = STOP;
          end else begin
            sample_next = sample_cnt + SAMPLE_W'(1);
          end
        end
      end
`endif

      STOP: begin
        if (tick) begin
          if (sample_cnt == SAMPLE_LAST) begin
            // Leave at mid stop bit so a zero-gap next start edge is caught
            sample_next = '0;
            state_next  = IDLE;
            if (!rxs) begin
              ferr_next = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (^{shift, parity_bit}) begin
              perr_next = 1'b1;
`endif
            end else begin
              data_next  = shift;
              valid_next = 1'b1;
            end
          end else begin
            sample_next = sample_cnt + SAMPLE_W'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
